// File: rtl/spi_ram_cmd_master_if.sv
// SPI byte-stream and Avalon-MM RAM signals seen by spi_ram_cmd_master.
// The master modport is the command decoder's view.
interface spi_ram_cmd_master_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              frame_active;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W-1:0] ram_address;
    logic [3:0]        ram_byteenable;
    logic              ram_chipselect;
    logic              ram_write;
    logic [31:0]       ram_writedata;
    logic [31:0]       ram_readdata;
    logic              cmd_error;

    modport master (
        input  frame_active, rx_data, rx_valid, tx_ready, ram_readdata,
        output rx_ready, tx_data, tx_valid, ram_address, ram_byteenable,
               ram_chipselect, ram_write, ram_writedata, cmd_error
    );

    modport slave (
        output frame_active, rx_data, rx_valid, tx_ready, ram_readdata,
        input  rx_ready, tx_data, tx_valid, ram_address, ram_byteenable,
               ram_chipselect, ram_write, ram_writedata, cmd_error
    );
endinterface

// File: rtl/spi_ram_cmd_master.sv
// SPI command decoder and Avalon-MM master: 0x02 writes bytes into RAM, 0x03 streams
// RAM bytes back, both from a 16-bit word address with auto-increment and wrap.
module spi_ram_cmd_master #(
    parameter int unsigned DEPTH_WORDS = 51200,
    parameter int unsigned ADDR_W      = 16
) (
    input logic                  clk,
    input logic                  reset,
    spi_ram_cmd_master_if.master bus
);
    localparam int unsigned       PTR_W     = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_WORDS - 1);

    typedef enum logic [3:0] {
        StIdle, StAddrHi, StAddrLo, StWrData, StWrPulse,
        StRdIssue, StRdCapt, StRdSend, StDiscard
    } state_e;

    state_e            r_state, w_state_d;
    logic [PTR_W-1:0]  r_ptr, w_ptr_d, w_ptr_inc;
    logic [7:0]        r_addr_hi;
    logic              r_is_read;
    logic [31:0]       r_shift;
    logic              r_cmd_error;
    logic              r_ram_cs, r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [3:0]        r_ram_be;
    logic [31:0]       r_ram_wdata;

    logic              w_rx_fire, w_tx_fire, w_cmd_ok;
    logic [ADDR_W-1:0] w_word, w_word_inc, w_addr_in, w_addr_ok;
    logic [1:0]        w_lane;

    assign w_rx_fire  = bus.rx_valid & bus.rx_ready;
    assign w_tx_fire  = bus.tx_valid & bus.tx_ready;
    assign w_cmd_ok   = (bus.rx_data == 8'h02) || (bus.rx_data == 8'h03);
    assign w_word     = r_ptr[PTR_W-1:2];
    assign w_lane     = r_ptr[1:0];
    assign w_word_inc = (w_word == LAST_WORD) ? '0 : w_word + 1'b1;
    assign w_ptr_inc  = (w_lane == 2'd3) ? {w_word_inc, 2'b00} : r_ptr + 1'b1;
    assign w_addr_in  = ADDR_W'({r_addr_hi, bus.rx_data});
    assign w_addr_ok  = (32'(w_addr_in) < DEPTH_WORDS) ? w_addr_in : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        unique case (r_state)
            StIdle:    if (w_rx_fire) w_state_d = w_cmd_ok ? StAddrHi : StDiscard;
            StAddrHi:  if (w_rx_fire) w_state_d = StAddrLo;
            StAddrLo: begin
                if (w_rx_fire) begin
                    w_ptr_d   = {w_addr_ok, 2'b00};
                    w_state_d = r_is_read ? StRdIssue : StWrData;
                end
            end
            StWrData:  if (w_rx_fire) w_state_d = StWrPulse;
            StWrPulse: begin
                w_ptr_d   = w_ptr_inc;
                w_state_d = StWrData;
            end
            StRdIssue: w_state_d = StRdCapt;
            StRdCapt:  w_state_d = StRdSend;
            StRdSend: begin
                if (w_tx_fire) begin
                    w_ptr_d = w_ptr_inc;
                    if (w_lane == 2'd3) w_state_d = StRdIssue;
                end
            end
            StDiscard: w_state_d = StDiscard;
            default:   w_state_d = StIdle;
        endcase
        // Chip-select release overrides everything; a registered WR_PULSE strobe still completes.
        if (!bus.frame_active) w_state_d = StIdle;
    end

    always_comb begin
        bus.rx_ready = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        if (reset) begin
            bus.rx_ready = 1'b1;
        end else if (bus.frame_active) begin
            case (r_state)
                StIdle, StAddrHi, StAddrLo, StWrData,
                StRdCapt, StRdSend, StDiscard: bus.rx_ready = 1'b1;
                default:                       bus.rx_ready = 1'b0;
            endcase
        end
        if (r_state == StRdSend) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = r_shift[{w_lane, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_addr_hi   <= 8'h00;
            r_is_read   <= 1'b0;
            r_shift     <= 32'h0;
            r_cmd_error <= 1'b0;
            r_ram_cs    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_be    <= 4'h0;
            r_ram_wdata <= 32'h0;
        end else begin
            r_ptr       <= w_ptr_d;
            r_cmd_error <= (r_state == StIdle) && w_rx_fire && !w_cmd_ok;
            if ((r_state == StIdle) && w_rx_fire) r_is_read <= (bus.rx_data == 8'h03);
            if ((r_state == StAddrHi) && w_rx_fire) r_addr_hi <= bus.rx_data;
            if (r_state == StRdCapt) r_shift <= bus.ram_readdata;
            // Strobes follow the next state so they are high exactly in WR_PULSE / RD_ISSUE.
            r_ram_cs <= (w_state_d == StWrPulse) || (w_state_d == StRdIssue);
            r_ram_we <= (w_state_d == StWrPulse);
            if (w_state_d == StWrPulse) begin
                r_ram_addr  <= w_ptr_d[PTR_W-1:2];
                r_ram_be    <= 4'b0001 << w_ptr_d[1:0];
                r_ram_wdata <= {4{bus.rx_data}};
            end else if (w_state_d == StRdIssue) begin
                r_ram_addr <= w_ptr_d[PTR_W-1:2];
                r_ram_be   <= 4'hF;
            end
        end
    end

    assign bus.ram_chipselect = r_ram_cs;
    assign bus.ram_write      = r_ram_we;
    assign bus.ram_address    = r_ram_addr;
    assign bus.ram_byteenable = r_ram_be;
    assign bus.ram_writedata  = r_ram_wdata;
    assign bus.cmd_error      = r_cmd_error;
endmodule
